pc_stack4: RTL and testbench
============================

Name: pc_stack4

Overview:
- 4-bit program-counter sequencer with a 4-entry return-address stack.
- Sits directly upstream of the 4-bit 2:1 next-address mux (mux2_4).
- Drives that mux's data inputs: a = sequential address, b = branch/return target. Also drives its select s.
- Registers the same next-address choice internally, so pc always equals what the mux selects.

Parameters:
- DEPTH, 4, return-stack entries; fixed at 4 for this revision, so sp width is 3 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  one clock; reset is synchronous and active-low
- op  input  3  operation: 000 HOLD, 001 INC, 010 JMP, 011 JZ, 100 CALL, 101 RET, 110/111 treated as HOLD
- addr  input  4  jump/call target
- z  input  1  zero flag qualifying JZ
- pc  output  4  current program counter (registered)
- mux_a  output  4  sequential address, pc+1 mod 16 (to mux2_4 a)
- mux_b  output  4  target address (to mux2_4 b)
- mux_s  output  1  1 = take target (to mux2_4 s)
- depth  output  3  stack occupancy, 0..4
- full  output  1  depth==4
- empty  output  1  depth==0
- err  output  1  sticky stack-fault flag

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc=0, depth=0, err=0, stack contents cleared to 0.
  - Reset overrides any op in the same cycle, including a reset asserted mid-sequence.
- Combinational outputs:
  - mux_a = pc+1, truncated to 4 bits; wraps 15 -> 0.
  - mux_b = addr for JMP/JZ/CALL; top-of-stack for RET; addr for all other ops.
  - mux_s = 1 for JMP; JZ with z==1; CALL when not full; RET when not empty. Otherwise 0.
  - full = (depth==4); empty = (depth==0).
- Next pc, one-cycle latency:
  - If mux_s==1: pc <= mux_b.
  - Else if op==INC, or op==JZ with z==0: pc <= mux_a.
  - Else (HOLD, undefined ops, faulting CALL/RET): pc unchanged.
- CALL, not full: push mux_a (return address = pc+1, wrapped), depth+1, pc <= addr, all in the same edge.
- CALL, full: no push, pc unchanged, depth unchanged, err <= 1.
- RET, not empty: pc <= top entry, depth-1. The popped entry's value is don't-care afterwards.
- RET, empty: pc unchanged, err <= 1.
- err is sticky; only reset clears it. It has no effect on subsequent operation.
- Stack organisation:
  - LIFO, indexed by depth.
  - Top-of-stack = entry[depth-1].
  - mux_b for RET with empty stack = 0.
- Simultaneous events: z is ignored for every op except JZ. Only one op per cycle, so push and pop never coincide.

Test Plan:
- Reset then INC x17 -> pc steps 0,1,…,15,0,1; mux_a always pc+1 mod 16; mux_s=0 throughout.
- pc=3, JMP addr=9 -> mux_s=1, mux_b=9 in that cycle; pc=9 next cycle. Then JZ addr=2 z=0 -> pc=10. Then JZ addr=2 z=1 -> pc=2.
- Nested calls: from pc=1, CALL 5, CALL 8, CALL 12, CALL 14 -> depth=4, full=1, pc=14, stack holds {2,6,9,13}. Then RET x4 -> pc 13, 9, 6, 2; depth 0; empty=1; err=0.
- Fault cases, part 1 (full stack): with depth=4, CALL addr=7 -> pc unchanged, depth=4, err=1.
- Fault cases, part 2 (from reset): RET on empty stack -> pc unchanged, depth=0, err=1. err stays 1 through a later INC and clears only on reset.
- Wrap and reset-mid-op:
  - pc=15, CALL addr=4 -> pushed return address 0, pc=4.
  - reset=0 asserted together with a CALL -> pc=0, depth=0, err=0 on that edge.
  - HOLD and op=111 leave pc unchanged.

Source files
------------

// File: rtl/pc_stack4.sv
// pc_stack4: 4-bit program-counter sequencer with a 4-entry return-address stack.
// Drives the a/b/s inputs of the downstream 2:1 next-address mux and tracks its choice in pc.
`default_nettype none

module pc_stack4 #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [3:0] addr,
  input  logic       z,
  output logic [3:0] pc,
  output logic [3:0] mux_a,
  output logic [3:0] mux_b,
  output logic       mux_s,
  output logic [2:0] depth,
  output logic       full,
  output logic       empty,
  output logic       err
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic [3:0] pc_q, pc_d;
  logic [2:0] depth_q;
  logic       err_q;
  logic [3:0] stack_q [DEPTH];

  logic [1:0] w_top_idx;
  logic [3:0] w_top;
  logic       w_push, w_pop, w_fault;

  assign full  = (depth_q == 3'(DEPTH));
  assign empty = (depth_q == 3'd0);
  assign mux_a = pc_q + 4'd1;

  // Two-bit index wraps depth 4 onto entry 3, so depth-1 is always a legal slot.
  assign w_top_idx = depth_q[1:0] - 2'd1;
  assign w_top     = empty ? 4'd0 : stack_q[w_top_idx];

  assign w_push  = (op == OP_CALL) && !full;
  assign w_pop   = (op == OP_RET)  && !empty;
  assign w_fault = ((op == OP_CALL) && full) || ((op == OP_RET) && empty);

  always_comb begin
    mux_b = addr;
    mux_s = 1'b0;
    case (op)
      OP_JMP:  mux_s = 1'b1;
      OP_JZ:   mux_s = z;
      OP_CALL: mux_s = !full;
      OP_RET:  begin
        mux_b = w_top;
        mux_s = !empty;
      end
      default: mux_s = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (mux_s) begin
      pc_d = mux_b;
    end else if ((op == OP_INC) || ((op == OP_JZ) && !z)) begin
      pc_d = mux_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= 4'd0;
      depth_q <= 3'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= 4'd0;
      end
    end else begin
      pc_q <= pc_d;
      if (w_push) begin
        stack_q[depth_q[1:0]] <= mux_a;
        depth_q               <= depth_q + 3'd1;
      end else if (w_pop) begin
        depth_q <= depth_q - 3'd1;
      end
      if (w_fault) begin
        err_q <= 1'b1;
      end
    end
  end

  assign pc    = pc_q;
  assign depth = depth_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack4.sv
// tb_pc_stack4: directed self-checking bench for pc_stack4.
`default_nettype none

module tb_pc_stack4;

  logic       clk;
  logic       reset;
  logic [2:0] op;
  logic [3:0] addr;
  logic       z;
  logic [3:0] pc;
  logic [3:0] mux_a;
  logic [3:0] mux_b;
  logic       mux_s;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] JZ   = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;

  pc_stack4 #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .addr  (addr),
    .z     (z),
    .pc    (pc),
    .mux_a (mux_a),
    .mux_b (mux_b),
    .mux_s (mux_s),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] o, input logic [3:0] a, input logic zz);
    op   = o;
    addr = a;
    z    = zz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_op(HOLD, 4'd0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_op(HOLD, 4'd0, 1'b0);
    tick();
    tick();
    chk("rst_pc", 8'(pc), 8'd0);
    chk("rst_depth", 8'(depth), 8'd0);
    chk("rst_empty", 8'(empty), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    reset = 1'b1;

    // INC x17 with wrap
    for (int i = 0; i < 17; i++) begin
      set_op(INC, 4'd7, 1'b1);
      #1;
      chk("inc_pc", 8'(pc), 8'(i % 16));
      chk("inc_mux_a", 8'(mux_a), 8'((i + 1) % 16));
      chk("inc_mux_s", 8'(mux_s), 8'd0);
      tick();
    end
    chk("inc_final_pc", 8'(pc), 8'd1);

    // JMP / JZ
    set_op(INC, 4'd0, 1'b0); tick(); tick();
    chk("pre_jmp_pc", 8'(pc), 8'd3);
    set_op(JMP, 4'd9, 1'b0); #1;
    chk("jmp_mux_s", 8'(mux_s), 8'd1);
    chk("jmp_mux_b", 8'(mux_b), 8'd9);
    tick();
    chk("jmp_pc", 8'(pc), 8'd9);
    set_op(JZ, 4'd2, 1'b0); #1;
    chk("jz0_mux_s", 8'(mux_s), 8'd0);
    tick();
    chk("jz0_pc", 8'(pc), 8'd10);
    set_op(JZ, 4'd2, 1'b1); #1;
    chk("jz1_mux_s", 8'(mux_s), 8'd1);
    tick();
    chk("jz1_pc", 8'(pc), 8'd2);

    // Nested calls from pc=1
    do_reset();
    set_op(INC, 4'd0, 1'b0); tick();
    chk("pre_call_pc", 8'(pc), 8'd1);
    set_op(CALL, 4'd5, 1'b0);  tick(); chk("call1_pc", 8'(pc), 8'd5);
    set_op(CALL, 4'd8, 1'b0);  tick(); chk("call2_pc", 8'(pc), 8'd8);
    set_op(CALL, 4'd12, 1'b0); tick(); chk("call3_pc", 8'(pc), 8'd12);
    set_op(CALL, 4'd14, 1'b0); tick();
    chk("call4_pc", 8'(pc), 8'd14);
    chk("call4_depth", 8'(depth), 8'd4);
    chk("call4_full", 8'(full), 8'd1);
    chk("call4_empty", 8'(empty), 8'd0);

    set_op(RET, 4'd0, 1'b0); #1; chk("ret1_mux_b", 8'(mux_b), 8'd13); tick(); chk("ret1_pc", 8'(pc), 8'd13);
    #1; chk("ret2_mux_b", 8'(mux_b), 8'd9);  tick(); chk("ret2_pc", 8'(pc), 8'd9);
    #1; chk("ret3_mux_b", 8'(mux_b), 8'd6);  tick(); chk("ret3_pc", 8'(pc), 8'd6);
    #1; chk("ret4_mux_b", 8'(mux_b), 8'd2);  tick(); chk("ret4_pc", 8'(pc), 8'd2);
    chk("ret_depth", 8'(depth), 8'd0);
    chk("ret_empty", 8'(empty), 8'd1);
    chk("ret_err", 8'(err), 8'd0);

    // Fault part 1: CALL on full stack
    set_op(CALL, 4'd3, 1'b0); tick(); tick(); tick(); tick();
    chk("refill_pc", 8'(pc), 8'd3);
    chk("refill_depth", 8'(depth), 8'd4);
    set_op(CALL, 4'd7, 1'b0); #1;
    chk("callfull_mux_s", 8'(mux_s), 8'd0);
    tick();
    chk("callfull_pc", 8'(pc), 8'd3);
    chk("callfull_depth", 8'(depth), 8'd4);
    chk("callfull_err", 8'(err), 8'd1);

    // Fault part 2: RET on empty stack
    do_reset();
    chk("rst2_err", 8'(err), 8'd0);
    set_op(RET, 4'd9, 1'b1); #1;
    chk("retempty_mux_b", 8'(mux_b), 8'd0);
    chk("retempty_mux_s", 8'(mux_s), 8'd0);
    tick();
    chk("retempty_pc", 8'(pc), 8'd0);
    chk("retempty_depth", 8'(depth), 8'd0);
    chk("retempty_err", 8'(err), 8'd1);
    set_op(INC, 4'd0, 1'b0); tick();
    chk("sticky_pc", 8'(pc), 8'd1);
    chk("sticky_err", 8'(err), 8'd1);
    do_reset();
    chk("errclr_err", 8'(err), 8'd0);

    // Wrap of return address
    set_op(JMP, 4'd15, 1'b0); tick();
    chk("wrap_pre_pc", 8'(pc), 8'd15);
    chk("wrap_mux_a", 8'(mux_a), 8'd0);
    set_op(CALL, 4'd4, 1'b0); tick();
    chk("wrap_call_pc", 8'(pc), 8'd4);
    chk("wrap_call_depth", 8'(depth), 8'd1);
    set_op(RET, 4'd0, 1'b0); #1;
    chk("wrap_ret_mux_b", 8'(mux_b), 8'd0);
    tick();
    chk("wrap_ret_pc", 8'(pc), 8'd0);
    tick();
    chk("wrap_err", 8'(err), 8'd1);

    // Reset together with a CALL
    set_op(CALL, 4'd11, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstcall_pc", 8'(pc), 8'd0);
    chk("rstcall_depth", 8'(depth), 8'd0);
    chk("rstcall_err", 8'(err), 8'd0);

    // HOLD and undefined ops
    set_op(JMP, 4'd6, 1'b0); tick();
    set_op(HOLD, 4'd3, 1'b1); tick();
    chk("hold_pc", 8'(pc), 8'd6);
    set_op(3'b111, 4'd3, 1'b1); #1;
    chk("op7_mux_s", 8'(mux_s), 8'd0);
    tick();
    chk("op7_pc", 8'(pc), 8'd6);
    set_op(3'b110, 4'd12, 1'b0); tick();
    chk("op6_pc", 8'(pc), 8'd6);
    chk("op6_depth", 8'(depth), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
